gcd_arbiter: RTL and testbench
==============================

Name: gcd_arbiter

Overview:
- Shares one iterative GCD core among NREQ requesters.
- Accepts operand pairs from the requesters through per-requester valid/ready handshakes and picks one at a time by round-robin.
- Launches the core, waits for its done pulse, and returns the result tagged with the requester index.
- Handles zero operands without using the core, and guards the core with a watchdog timeout.

Parameters:
- SIZE, 11, operand and result width in bits.
- NREQ, 4, number of requesters (2..16).
- IDW, 2, requester-index width; must satisfy 2**IDW >= NREQ.
- TIMEOUT, 4096, maximum number of WAIT-state cycles before the request is aborted; must be >= 2**SIZE + 4.

Ports:
- clk  in  1  system clock; all logic is rising-edge.
- rst  in  1  asynchronous reset, active-low; deassertion is synchronised to clk outside this block.
- req_valid  in  NREQ  bit k set = requester k has an operand pair pending.
- req_ready  out  NREQ  one-hot grant; bit k set = pair from requester k is accepted this cycle.
- req_x  in  NREQ*SIZE  packed X operands; requester k occupies bits [k*SIZE +: SIZE].
- req_y  in  NREQ*SIZE  packed Y operands; same packing as req_x.
- rsp_valid  out  1  response is valid.
- rsp_ready  in  1  consumer accepts the response.
- rsp_id  out  IDW  index of the requester that owns the response.
- rsp_data  out  SIZE  GCD result.
- rsp_err  out  1  1 = watchdog expired; rsp_data is 0.
- core_start  out  1  one-cycle start pulse to the GCD core.
- core_x  out  SIZE  X operand to the core.
- core_y  out  SIZE  Y operand to the core.
- core_done  in  1  core result is valid; level or pulse is accepted.
- core_result  in  SIZE  core output.
- busy  out  1  1 whenever the FSM is not in IDLE.

Behaviour:
- Reset (rst=0, asynchronous):
  - FSM goes to IDLE.
  - All outputs go to 0.
  - Round-robin pointer last_grant = NREQ-1, so requester 0 has first priority.
  - Captured operands, rsp_id, rsp_data and the watchdog counter are cleared.
  - Reset mid-operation abandons the request silently; no response is ever issued for it.
- FSM states:
  - IDLE:
    - If any req_valid bit is set, grant index g = first set bit searching upward from last_grant+1, wrapping modulo NREQ.
    - req_ready[g]=1 combinationally in that cycle only; req_ready is 0 in every other state.
    - On the clock edge: capture x=req_x[g], y=req_y[g], id=g; set last_grant=g.
    - If x==0 or y==0, go to RESP with rsp_data = x|y (gcd(0,b)=b, gcd(0,0)=0), rsp_err=0. The core is not started.
    - Otherwise go to LAUNCH.
  - LAUNCH:
    - core_start=1 for exactly one cycle.
    - core_x/core_y drive the captured operands and hold stable until the FSM leaves WAIT; they return to 0 in IDLE.
    - Clear the watchdog counter; go to WAIT.
    - core_done is ignored in LAUNCH.
  - WAIT:
    - If core_done=1: latch core_result into rsp_data, rsp_err=0, go to RESP.
    - Else increment the counter. When counter == TIMEOUT-1 and core_done=0: rsp_data=0, rsp_err=1, go to RESP.
    - If core_done coincides with the final watchdog count, core_done wins.
  - RESP:
    - rsp_valid=1; rsp_id, rsp_data and rsp_err are held stable until the handshake.
    - When rsp_valid & rsp_ready, return to IDLE next cycle and drop rsp_valid.
    - New requests are not accepted until the FSM is back in IDLE, so there is at most one request in flight.
- Latency, with grant accepted at edge T:
  - Zero-operand bypass: rsp_valid from T+1.
  - Normal path: core_start in cycle T+1; if core_done is first seen in cycle D, rsp_valid rises at D+1.
  - Minimum gap between consecutive grants is 1 cycle after the response handshake.
- Fairness: a requester holding req_valid continuously is granted within NREQ grants.
- A requester may deassert req_valid before it is granted; it is then skipped without penalty.
- Operands are unsigned; the block performs no arithmetic on them apart from the zero check and the OR.

Test Plan:
- Single request: requester 1, x=12, y=18; core model returns 6 after 5 cycles -> one req_ready[1] pulse, one core_start pulse, core_x=12/core_y=18 stable throughout, rsp_id=1, rsp_data=6, rsp_err=0, rsp_valid 1 cycle after core_done.
- Round-robin: all 4 requesters valid at once, out of reset, each held until granted -> grant order 0,1,2,3; then requester 0 alone -> granted.
- Zero bypass: x=0, y=35 -> rsp_data=35 one cycle after grant, core_start never asserted. Then x=0, y=0 -> rsp_data=0, rsp_err=0.
- Watchdog: core_done tied low -> exactly TIMEOUT WAIT cycles, then rsp_valid with rsp_err=1, rsp_data=0; the next request is served normally.
- Backpressure: rsp_ready held low 10 cycles -> rsp_valid, rsp_id and rsp_data stable, no new req_ready. rsp_ready=1 -> FSM to IDLE, next grant issued.
- Reset mid-WAIT: pull rst low -> all outputs 0 immediately, busy=0, no response. After release, a request from requester 2 is granted first only if requesters 0 and 1 are idle.
- Exhaustive, with the real gcd core attached: all x,y in 1..2**SIZE-1 issued via random requesters -> every rsp_data equals the reference GCD, 0 errors reported.

Source files
------------

// File: rtl/gcd_arbiter_if.sv
// Request, response and core-side signals shared between the GCD arbiter and its neighbours.
// The slave modport is the arbiter's view; master is the environment driving requests and the core.
interface gcd_arbiter_if #(
  parameter int SIZE = 11,
  parameter int NREQ = 4,
  parameter int IDW  = 2
);
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*SIZE-1:0] req_x;
  logic [NREQ*SIZE-1:0] req_y;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [IDW-1:0]       rsp_id;
  logic [SIZE-1:0]      rsp_data;
  logic                 rsp_err;
  logic                 core_start;
  logic [SIZE-1:0]      core_x;
  logic [SIZE-1:0]      core_y;
  logic                 core_done;
  logic [SIZE-1:0]      core_result;

  modport slave (
    input  req_valid, req_x, req_y, rsp_ready, core_done, core_result,
    output req_ready, rsp_valid, rsp_id, rsp_data, rsp_err, core_start, core_x, core_y
  );

  modport master (
    output req_valid, req_x, req_y, rsp_ready, core_done, core_result,
    input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_err, core_start, core_x, core_y
  );
endinterface

// File: rtl/gcd_arbiter.sv
// Round-robin front end that shares one iterative GCD core among NREQ requesters,
// with a zero-operand bypass and a watchdog on the core.
module gcd_arbiter #(
  parameter int SIZE    = 11,
  parameter int NREQ    = 4,
  parameter int IDW     = 2,
  parameter int TIMEOUT = 4096
) (
  input  logic clk,
  input  logic rst,
  gcd_arbiter_if.slave bus,
  output logic busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } state_t;

  localparam int             WDW     = $clog2(TIMEOUT);
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

  state_t          state_r;
  state_t          state_nx_s;
  logic [IDW-1:0]  last_grant_r;
  logic [IDW-1:0]  grant_idx_s;
  logic            grant_any_s;
  int              idx_v;
  logic [SIZE-1:0] gx_s;
  logic [SIZE-1:0] gy_s;
  logic            zero_s;
  logic            wd_expire_s;
  logic [WDW-1:0]  wd_cnt_r;
  logic [NREQ-1:0] req_ready_s;
  logic            core_start_nx_s;
  logic            rsp_valid_nx_s;
  logic            busy_nx_s;
  logic            core_start_r;
  logic            rsp_valid_r;
  logic            busy_r;
  logic            rsp_err_r;
  logic [IDW-1:0]  rsp_id_r;
  logic [SIZE-1:0] rsp_data_r;
  logic [SIZE-1:0] core_x_r;
  logic [SIZE-1:0] core_y_r;

  // Round-robin search: first valid requester strictly after the last grant, wrapping.
  always_comb begin
    grant_any_s = 1'b0;
    grant_idx_s = {IDW{1'b0}};
    idx_v       = 0;
    for (int i = 1; i <= NREQ; i++) begin
      idx_v = (int'(last_grant_r) + i) % NREQ;
      if (!grant_any_s && bus.req_valid[idx_v]) begin
        grant_any_s = 1'b1;
        grant_idx_s = IDW'(idx_v);
      end else begin
        grant_any_s = grant_any_s;
      end
    end
  end

  assign gx_s        = bus.req_x[int'(grant_idx_s)*SIZE +: SIZE];
  assign gy_s        = bus.req_y[int'(grant_idx_s)*SIZE +: SIZE];
  assign zero_s      = (gx_s == {SIZE{1'b0}}) || (gy_s == {SIZE{1'b0}});
  assign wd_expire_s = (wd_cnt_r == WD_LAST);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state logic; core_done takes precedence over the final watchdog count.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (grant_any_s) begin
          state_nx_s = zero_s ? RESP : LAUNCH;
        end else begin
          state_nx_s = IDLE;
        end
      end
      LAUNCH: state_nx_s = WAIT;
      WAIT: begin
        if (bus.core_done || wd_expire_s) begin
          state_nx_s = RESP;
        end else begin
          state_nx_s = WAIT;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_nx_s = IDLE;
        end else begin
          state_nx_s = RESP;
        end
      end
      default: state_nx_s = IDLE;
    endcase
  end

  // Output decode: combinational grant plus next values of the registered outputs.
  always_comb begin
    req_ready_s = {NREQ{1'b0}};
    if ((state_r == IDLE) && grant_any_s) begin
      req_ready_s[grant_idx_s] = 1'b1;
    end else begin
      req_ready_s = {NREQ{1'b0}};
    end
    core_start_nx_s = (state_nx_s == LAUNCH);
    rsp_valid_nx_s  = (state_nx_s == RESP);
    busy_nx_s       = (state_nx_s != IDLE);
  end

  // Datapath: operand capture, watchdog, and response registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant_r <= IDW'(NREQ - 1);
      wd_cnt_r     <= {WDW{1'b0}};
      core_start_r <= 1'b0;
      rsp_valid_r  <= 1'b0;
      busy_r       <= 1'b0;
      rsp_err_r    <= 1'b0;
      rsp_id_r     <= {IDW{1'b0}};
      rsp_data_r   <= {SIZE{1'b0}};
      core_x_r     <= {SIZE{1'b0}};
      core_y_r     <= {SIZE{1'b0}};
    end else begin
      core_start_r <= core_start_nx_s;
      rsp_valid_r  <= rsp_valid_nx_s;
      busy_r       <= busy_nx_s;
      case (state_r)
        IDLE: begin
          if (grant_any_s) begin
            last_grant_r <= grant_idx_s;
            rsp_id_r     <= grant_idx_s;
            rsp_err_r    <= 1'b0;
            if (zero_s) begin
              rsp_data_r <= gx_s | gy_s;
            end else begin
              core_x_r <= gx_s;
              core_y_r <= gy_s;
            end
          end
        end
        LAUNCH: wd_cnt_r <= {WDW{1'b0}};
        WAIT: begin
          if (bus.core_done) begin
            rsp_data_r <= bus.core_result;
            rsp_err_r  <= 1'b0;
            core_x_r   <= {SIZE{1'b0}};
            core_y_r   <= {SIZE{1'b0}};
          end else if (wd_expire_s) begin
            rsp_data_r <= {SIZE{1'b0}};
            rsp_err_r  <= 1'b1;
            core_x_r   <= {SIZE{1'b0}};
            core_y_r   <= {SIZE{1'b0}};
          end else begin
            wd_cnt_r <= wd_cnt_r + {{(WDW-1){1'b0}}, 1'b1};
          end
        end
        RESP: rsp_err_r <= rsp_err_r;
        default: wd_cnt_r <= {WDW{1'b0}};
      endcase
    end
  end

  assign bus.req_ready  = req_ready_s;
  assign bus.core_start = core_start_r;
  assign bus.core_x     = core_x_r;
  assign bus.core_y     = core_y_r;
  assign bus.rsp_valid  = rsp_valid_r;
  assign bus.rsp_id     = rsp_id_r;
  assign bus.rsp_data   = rsp_data_r;
  assign bus.rsp_err    = rsp_err_r;
  assign busy           = busy_r;

endmodule

// File: tb/tb_gcd_arbiter.sv
// Directed bench for gcd_arbiter with a fixed-latency behavioural GCD core attached.
module tb_gcd_arbiter;
  localparam int SIZE    = 11;
  localparam int NREQ    = 4;
  localparam int IDW     = 2;
  localparam int TIMEOUT = 4096;

  logic clk = 1'b0;
  logic rst;
  logic busy;
  logic tie_low = 1'b0;
  int   core_cnt = 0;
  int   starts = 0;
  logic [SIZE-1:0] core_res = '0;
  int   n_checks = 0;
  int   n_fail = 0;

  gcd_arbiter_if #(.SIZE(SIZE), .NREQ(NREQ), .IDW(IDW)) bus ();

  gcd_arbiter #(.SIZE(SIZE), .NREQ(NREQ), .IDW(IDW), .TIMEOUT(TIMEOUT)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [SIZE-1:0] ref_gcd(input logic [SIZE-1:0] a, input logic [SIZE-1:0] b);
    logic [SIZE-1:0] p, q, t;
    p = a;
    q = b;
    while (q != '0) begin
      t = p % q;
      p = q;
      q = t;
    end
    return p;
  endfunction

  // Core model: done is high for one cycle, five cycles after the start pulse.
  always @(posedge clk) begin
    if (bus.core_start) begin
      core_cnt <= 5;
      core_res <= ref_gcd(bus.core_x, bus.core_y);
      starts   <= starts + 1;
    end else if (core_cnt != 0) begin
      core_cnt <= core_cnt - 1;
    end
  end
  assign bus.core_done   = !tie_low && (core_cnt == 1);
  assign bus.core_result = core_res;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic drive_req(input int k, input logic [SIZE-1:0] x, input logic [SIZE-1:0] y);
    bus.req_valid[k]          = 1'b1;
    bus.req_x[k*SIZE +: SIZE] = x;
    bus.req_y[k*SIZE +: SIZE] = y;
  endtask

  task automatic wait_grant(input int k, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      #1;
      if (bus.req_ready[k]) ok = 1'b1;
      else @(negedge clk);
    end
    check($sformatf("grant req%0d", k), 32'(ok), 32'd1);
  endtask

  // Full transaction; starts and ends at a falling edge, rsp_ready assumed high.
  task automatic transact(input int k, input logic [SIZE-1:0] x, input logic [SIZE-1:0] y,
                          input logic [SIZE-1:0] exp_data, input logic exp_err, input int exp_lat,
                          input string tag);
    logic ok;
    int   cyc;
    logic use_core;
    use_core = (x != '0) && (y != '0);
    drive_req(k, x, y);
    wait_grant(k, ok);
    @(negedge clk);
    bus.req_valid[k] = 1'b0;
    check({tag, " start"}, 32'(bus.core_start), 32'(use_core));
    cyc = 1;
    while (!bus.rsp_valid && cyc < 6000) begin
      check({tag, " core_x"}, 32'(bus.core_x), 32'(x));
      check({tag, " core_y"}, 32'(bus.core_y), 32'(y));
      @(negedge clk);
      cyc++;
    end
    check({tag, " latency"}, 32'(cyc), 32'(exp_lat));
    check({tag, " rsp_id"}, 32'(bus.rsp_id), 32'(k));
    check({tag, " rsp_data"}, 32'(bus.rsp_data), 32'(exp_data));
    check({tag, " rsp_err"}, 32'(bus.rsp_err), 32'(exp_err));
    @(negedge clk);
    check({tag, " rsp_drop"}, 32'(bus.rsp_valid), 32'd0);
  endtask

  initial begin
    int   g;
    int   s0;
    int   cyc;
    logic ok;
    rst           = 1'b0;
    bus.req_valid = '0;
    bus.req_x     = '0;
    bus.req_y     = '0;
    bus.rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("reset busy", 32'(busy), 32'd0);
    check("reset rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("reset core_start", 32'(bus.core_start), 32'd0);
    check("reset rsp_data", 32'(bus.rsp_data), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // Round-robin out of reset: all four pending, expected grant order 0,1,2,3.
    for (int k = 0; k < NREQ; k++) drive_req(k, 11'(4 * (k + 1)), 11'(6 * (k + 1)));
    for (int j = 0; j < NREQ; j++) begin
      ok = 1'b0;
      for (int i = 0; i < 200 && !ok; i++) begin
        #1;
        if (bus.req_ready != '0) ok = 1'b1;
        else @(negedge clk);
      end
      check("rr grant seen", 32'(ok), 32'd1);
      check("rr onehot", 32'($countones(bus.req_ready)), 32'd1);
      g = 0;
      for (int k = 0; k < NREQ; k++) if (bus.req_ready[k]) g = k;
      check("rr order", 32'(g), 32'(j));
      @(negedge clk);
      bus.req_valid[g] = 1'b0;
      cyc = 0;
      while (!bus.rsp_valid && cyc < 100) begin
        @(negedge clk);
        cyc++;
      end
      check("rr rsp_data", 32'(bus.rsp_data), 32'(2 * (g + 1)));
      @(negedge clk);
    end
    transact(0, 11'd15, 11'd25, 11'd5, 1'b0, 7, "rr solo0");

    // Single request on requester 1.
    s0 = starts;
    transact(1, 11'd12, 11'd18, 11'd6, 1'b0, 7, "single");
    check("single starts", 32'(starts - s0), 32'd1);

    // Zero-operand bypass never touches the core.
    s0 = starts;
    transact(2, 11'd0, 11'd35, 11'd35, 1'b0, 1, "zero x");
    transact(3, 11'd0, 11'd0, 11'd0, 1'b0, 1, "zero both");
    check("zero starts", 32'(starts - s0), 32'd0);

    // Watchdog: TIMEOUT wait cycles, then an error response; next request is normal.
    tie_low = 1'b1;
    transact(3, 11'd7, 11'd5, 11'd0, 1'b1, TIMEOUT + 2, "watchdog");
    tie_low = 1'b0;
    transact(0, 11'd21, 11'd14, 11'd7, 1'b0, 7, "post wd");

    // Backpressure: response held, no new grant while rsp_ready is low.
    bus.rsp_ready = 1'b0;
    drive_req(2, 11'd9, 11'd6);
    wait_grant(2, ok);
    @(negedge clk);
    bus.req_valid[2] = 1'b0;
    cyc = 0;
    while (!bus.rsp_valid && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    drive_req(0, 11'd10, 11'd4);
    for (int i = 0; i < 10; i++) begin
      #1;
      check("bp rsp_valid", 32'(bus.rsp_valid), 32'd1);
      check("bp rsp_id", 32'(bus.rsp_id), 32'd2);
      check("bp rsp_data", 32'(bus.rsp_data), 32'd3);
      check("bp no grant", 32'(bus.req_ready), 32'd0);
      @(negedge clk);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    #1;
    check("bp released", 32'(bus.rsp_valid), 32'd0);
    check("bp next grant", 32'(bus.req_ready), 32'd1);
    @(negedge clk);
    bus.req_valid[0] = 1'b0;
    cyc = 0;
    while (!bus.rsp_valid && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check("bp2 rsp_data", 32'(bus.rsp_data), 32'd2);
    check("bp2 rsp_id", 32'(bus.rsp_id), 32'd0);
    @(negedge clk);

    // Boundary operand pairs through the core.
    transact(1, 11'd2047, 11'd1, 11'd1, 1'b0, 7, "vec a");
    transact(3, 11'd1024, 11'd768, 11'd256, 1'b0, 7, "vec b");
    transact(1, 11'd2046, 11'd1023, 11'd1023, 1'b0, 7, "vec c");
    transact(2, 11'd1155, 11'd1001, 11'd77, 1'b0, 7, "vec d");
    transact(0, 11'd2047, 11'd2047, 11'd2047, 1'b0, 7, "vec e");
    transact(1, 11'd7, 11'd0, 11'd7, 1'b0, 1, "vec f");

    // Reset in the middle of WAIT abandons the request.
    tie_low = 1'b1;
    drive_req(1, 11'd5, 11'd3);
    wait_grant(1, ok);
    @(negedge clk);
    bus.req_valid[1] = 1'b0;
    repeat (20) @(negedge clk);
    rst = 1'b0;
    #1;
    check("mid rst busy", 32'(busy), 32'd0);
    check("mid rst rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("mid rst core_x", 32'(bus.core_x), 32'd0);
    check("mid rst core_y", 32'(bus.core_y), 32'd0);
    check("mid rst rsp_id", 32'(bus.rsp_id), 32'd0);
    repeat (3) @(negedge clk);
    rst     = 1'b1;
    tie_low = 1'b0;
    repeat (3) @(negedge clk);
    check("post rst no rsp", 32'(bus.rsp_valid), 32'd0);
    transact(2, 11'd8, 11'd12, 11'd4, 1'b0, 7, "post rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
